regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 110 +++++++++++
 tb/tb_regfile_param.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parameterised register file: one write port, two combinational read ports,
// optional hardwired-zero register 0, optional write-to-read forwarding and a clear sweep FSM.
module regfile_param #(
    parameter int WIDTH    = 16,
    parameter int AW       = 3,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic             clr,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy
);

    localparam int N = 1 << AW;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    w_idx_nx;
    logic [WIDTH-1:0] r_mem [N];

    logic             w_we;
    logic [AW-1:0]    w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_rd_live;

    // Read mux: zero while sweeping or in reset, then zero-register, then forwarding.
    function automatic logic [WIDTH-1:0] f_read(
        input logic             live,
        input logic [AW-1:0]    ra,
        input logic [WIDTH-1:0] stored,
        input logic             fwd_we,
        input logic [AW-1:0]    fwd_wa,
        input logic [WIDTH-1:0] fwd_wd
    );
        if (!live)
            return '0;
        if ((ZERO_REG != 0) && (ra == '0))
            return '0;
        if ((BYPASS != 0) && fwd_we && (fwd_wa == ra))
            return fwd_wd;
        return stored;
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_we       = 1'b0;
        w_waddr    = wa3;
        w_wdata    = wd3;
        case (r_state)
            S_IDLE: begin
                // A clear request wins over a same-cycle write.
                if (clr) begin
                    w_state_nx = S_CLEAR;
                    w_idx_nx   = '0;
                end else if (we3 && !((ZERO_REG != 0) && (wa3 == '0))) begin
                    w_we = 1'b1;
                end
            end
            S_CLEAR: begin
                w_we     = 1'b1;
                w_waddr  = r_idx;
                w_wdata  = '0;
                w_idx_nx = r_idx + 1'b1;
                if (r_idx == '1)
                    w_state_nx = S_IDLE;
            end
            default: begin
                w_state_nx = S_CLEAR;
                w_idx_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_CLEAR;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    assign w_rd_live = (r_state == S_IDLE) && !reset;

    assign rd1  = f_read(w_rd_live, ra1, r_mem[ra1], we3, wa3, wd3);
    assign rd2  = f_read(w_rd_live, ra2, r_mem[ra2], we3, wa3, wd3);
    assign busy = (r_state == S_CLEAR);

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations driven side by side and checked
// against an array/countdown model of the register file behaviour.
module tb_regfile_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 0: defaults. Instance 1: BYPASS=0, ZERO_REG=0. Instance 2: WIDTH=32, AW=5.
    logic        rst [3];
    logic        we  [3];
    logic        clr [3];
    logic [4:0]  wa  [3];
    logic [4:0]  ra1 [3];
    logic [4:0]  ra2 [3];
    logic [31:0] wd  [3];

    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic [31:0] c_rd1, c_rd2;
    logic        a_busy, b_busy, c_busy;

    regfile_param u_a (
        .clk(clk), .reset(rst[0]), .we3(we[0]), .wa3(wa[0][2:0]), .wd3(wd[0][15:0]),
        .ra1(ra1[0][2:0]), .ra2(ra2[0][2:0]), .clr(clr[0]),
        .rd1(a_rd1), .rd2(a_rd2), .busy(a_busy)
    );

    regfile_param #(.WIDTH(16), .AW(3), .ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .reset(rst[1]), .we3(we[1]), .wa3(wa[1][2:0]), .wd3(wd[1][15:0]),
        .ra1(ra1[1][2:0]), .ra2(ra2[1][2:0]), .clr(clr[1]),
        .rd1(b_rd1), .rd2(b_rd2), .busy(b_busy)
    );

    regfile_param #(.WIDTH(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) u_c (
        .clk(clk), .reset(rst[2]), .we3(we[2]), .wa3(wa[2]), .wd3(wd[2]),
        .ra1(ra1[2]), .ra2(ra2[2]), .clr(clr[2]),
        .rd1(c_rd1), .rd2(c_rd2), .busy(c_busy)
    );

    // Reference model: register contents plus number of sweep cycles still to run.
    logic [31:0] m [3][32];
    int          rem [3];
    int          nreg [3]  = '{8, 8, 32};
    bit          zr [3]    = '{1'b1, 1'b0, 1'b1};
    bit          bp [3]    = '{1'b1, 1'b0, 1'b1};
    logic [31:0] wmask [3] = '{32'h0000FFFF, 32'h0000FFFF, 32'hFFFFFFFF};
    int          cnt [3];

    function automatic logic [31:0] obs_rd(int k, int p);
        case (k)
            0:       return (p == 1) ? {16'h0, a_rd1} : {16'h0, a_rd2};
            1:       return (p == 1) ? {16'h0, b_rd1} : {16'h0, b_rd2};
            default: return (p == 1) ? c_rd1 : c_rd2;
        endcase
    endfunction

    function automatic logic obs_busy(int k);
        case (k)
            0:       return a_busy;
            1:       return b_busy;
            default: return c_busy;
        endcase
    endfunction

    function automatic logic [31:0] model_rd(int k, logic [4:0] ra);
        int a  = int'(ra) & (nreg[k] - 1);
        int wa_i = int'(wa[k]) & (nreg[k] - 1);
        if (rst[k] || rem[k] > 0) return 32'h0;
        if (zr[k] && a == 0) return 32'h0;
        if (bp[k] && we[k] && wa_i == a) return wd[k] & wmask[k];
        return m[k][a];
    endfunction

    task automatic model_edge(int k);
        int a = int'(wa[k]) & (nreg[k] - 1);
        if (rst[k]) begin
            rem[k] = nreg[k];
        end else if (rem[k] > 0) begin
            m[k][nreg[k] - rem[k]] = 32'h0;
            rem[k] = rem[k] - 1;
        end else if (clr[k]) begin
            rem[k] = nreg[k];
        end else if (we[k] && !(zr[k] && a == 0)) begin
            m[k][a] = wd[k] & wmask[k];
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check read ports before the edge, advance model, check busy after it.
    task automatic step();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rd1_i%0d", k), obs_rd(k, 1), model_rd(k, ra1[k]));
            chk($sformatf("rd2_i%0d", k), obs_rd(k, 2), model_rd(k, ra2[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("busy_i%0d", k), {31'h0, obs_busy(k)}, (rem[k] > 0) ? 32'h1 : 32'h0);
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b0; we[k] = 1'b0; clr[k] = 1'b0;
            wa[k] = '0; ra1[k] = '0; ra2[k] = '0; wd[k] = '0;
        end
    endtask

    task automatic count_sweeps(bit wr_a);
        cnt = '{0, 0, 0};
        for (int t = 0; t < 100 && (a_busy || b_busy || c_busy); t++) begin
            for (int k = 0; k < 3; k++) if (obs_busy(k)) cnt[k]++;
            if (wr_a) begin
                we[0] = 1'b1;
                wa[0] = 5'($urandom_range(1, 7));
                wd[0] = $urandom;
            end
            step();
        end
        we[0] = 1'b0;
    endtask

    task automatic read_all_zero(int k);
        for (int r = 0; r < nreg[k]; r++) begin
            ra1[k] = 5'(r);
            ra2[k] = 5'(nreg[k] - 1 - r);
            step();
            chk($sformatf("zero_rd1_i%0d_r%0d", k, r), obs_rd(k, 1), 32'h0);
            chk($sformatf("zero_rd2_i%0d_r%0d", k, r), obs_rd(k, 2), 32'h0);
        end
    endtask

    initial begin
        int n;
        for (int k = 0; k < 3; k++) begin
            rem[k] = 0;
            for (int r = 0; r < 32; r++) m[k][r] = 32'h0;
        end
        idle_inputs();

        // Reset for two cycles on every instance, then measure each sweep.
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        step();
        chk("rst_busy_a", {31'h0, a_busy}, 32'h1);
        chk("rst_rd1_a", {16'h0, a_rd1}, 32'h0);
        step();
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        count_sweeps(1'b0);
        chk("rst_sweep_len_a", cnt[0], 8);
        chk("rst_sweep_len_b", cnt[1], 8);
        chk("rst_sweep_len_c", cnt[2], 32);
        read_all_zero(0);
        read_all_zero(1);

        // Forwarding versus no forwarding on a write to address 5.
        we[1] = 1'b1; wa[1] = 5'd5; wd[1] = 32'h1111;
        step();
        for (int k = 0; k < 2; k++) begin
            we[k] = 1'b1; wa[k] = 5'd5; wd[k] = 32'hBEEF; ra1[k] = 5'd5;
        end
        #1;
        chk("bypass_same_cycle_a", {16'h0, a_rd1}, 32'hBEEF);
        chk("nobypass_old_b", {16'h0, b_rd1}, 32'h1111);
        step();
        we[0] = 1'b0; we[1] = 1'b0;
        #1;
        chk("bypass_after_edge_a", {16'h0, a_rd1}, 32'hBEEF);
        chk("nobypass_after_edge_b", {16'h0, b_rd1}, 32'hBEEF);

        // Writes to address 0.
        for (int k = 0; k < 2; k++) begin
            we[k] = 1'b1; wa[k] = 5'd0; wd[k] = 32'h1234; ra1[k] = 5'd0; ra2[k] = 5'd0;
        end
        #1;
        chk("zero_reg_fwd_rd1_a", {16'h0, a_rd1}, 32'h0);
        chk("zero_reg_fwd_rd2_a", {16'h0, a_rd2}, 32'h0);
        step();
        we[0] = 1'b0; we[1] = 1'b0;
        #1;
        chk("zero_reg_rd1_a", {16'h0, a_rd1}, 32'h0);
        chk("zero_reg_rd2_a", {16'h0, a_rd2}, 32'h0);
        chk("reg0_rd1_b", {16'h0, b_rd1}, 32'h1234);
        chk("reg0_rd2_b", {16'h0, b_rd2}, 32'h1234);

        // Load 1..7, read back, then clear while attempting writes.
        for (int i = 1; i < 8; i++) begin
            we[0] = 1'b1; wa[0] = 5'(i); wd[0] = 32'h0011 * i;
            step();
        end
        we[0] = 1'b0;
        for (int i = 1; i < 8; i++) begin
            ra1[0] = 5'(i);
            step();
            chk($sformatf("load_r%0d", i), {16'h0, a_rd1}, 32'h0011 * i);
        end
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        count_sweeps(1'b1);
        chk("clr_sweep_len_a", cnt[0], 8);
        read_all_zero(0);

        // clr during the sweep is ignored.
        clr[0] = 1'b1;
        step();
        n = 0;
        while (a_busy && n < 100) begin
            n++;
            clr[0] = (n == 4);
            step();
        end
        clr[0] = 1'b0;
        chk("clr_mid_sweep_len", n, 8);

        // reset during the sweep restarts it.
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        n = 0;
        while (a_busy && n < 100) begin
            n++;
            rst[0] = (n == 4);
            step();
        end
        rst[0] = 1'b0;
        chk("rst_mid_sweep_len_after", n - 4, 8);
        read_all_zero(0);

        // Wide configuration: top address round trip.
        we[2] = 1'b1; wa[2] = 5'd31; wd[2] = 32'hDEADBEEF; ra1[2] = 5'd31;
        step();
        we[2] = 1'b0;
        #1;
        chk("wide_addr31", c_rd1, 32'hDEADBEEF);

        // Randomised traffic on all instances.
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < 3; k++) begin
                rst[k] = ($urandom_range(0, 99) == 0);
                clr[k] = ($urandom_range(0, 39) == 0);
                we[k]  = 1'($urandom_range(0, 1));
                wa[k]  = 5'($urandom_range(0, nreg[k] - 1));
                wd[k]  = $urandom;
                ra1[k] = $urandom_range(0, 1) ? wa[k] : 5'($urandom_range(0, nreg[k] - 1));
                ra2[k] = 5'($urandom_range(0, nreg[k] - 1));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
